// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache refill path: scheduler state, port identifiers
// and the helper that sizes the byte offset within one cache line.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } refill_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_ICACHE = 1'b0;
    localparam port_id_t PORT_DCACHE = 1'b1;

    // Number of low address bits that select a byte inside one line.
    function automatic int unsigned line_off_w(input int unsigned line_words,
                                               input int unsigned data_width);
        return $clog2(line_words * data_width / 8);
    endfunction

endpackage

// File: rtl/cache_rr_arb.sv
// Two-input round-robin arbiter.
// Ports: clk, reset_n (async active-low); req - request vector;
// advance - pulse to move priority; served - port just completed;
// gnt - combinational one-hot grant (zero when no request).
module cache_rr_arb
    import cache_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  port_id_t   served,
    output logic [1:0] gnt
);

    port_id_t prio;

    // Priority pointer: after a line completes, the other port goes first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= PORT_ICACHE;
        end else if (advance) begin
            prio <= ~served;
        end
    end

    // Grant the priority port if it asks, otherwise the other one.
    always_comb begin
        gnt = 2'b00;
        if (req[prio]) begin
            gnt[prio] = 1'b1;
        end else if (req[~prio]) begin
            gnt[~prio] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_refill_sched.sv
// Refill scheduler sharing one word-wide memory read port between the
// I-cache (port 0) and D-cache (port 1). Accepts a miss address, bursts
// LINE_WORDS single-word reads in ascending order, streams the returned
// words back tagged with port and index, then pulses a per-port ack.
// Ports:
//   clk, reset_n                - clock, async active-low reset
//   req_vld_i/req_rdy_o/req_addr_i - per-port miss handshake and address
//   ack_o                       - one-cycle line-complete pulse per port
//   fill_vld_o/port/idx/data    - returned words toward the caches
//   mem_req_o/mem_gnt_i/mem_addr_o - read request channel
//   mem_rvld_i/mem_rdata_i      - in-order read data channel
module cache_refill_sched
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [1:0]                    req_vld_i,
    output logic [1:0]                    req_rdy_o,
    input  logic [2*ADDR_WIDTH-1:0]       req_addr_i,
    output logic [1:0]                    ack_o,
    output logic                          fill_vld_o,
    output logic                          fill_port_o,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx_o,
    output logic [DATA_WIDTH-1:0]         fill_data_o,
    output logic                          mem_req_o,
    input  logic                          mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    input  logic                          mem_rvld_i,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

    localparam int unsigned IDX_W   = $clog2(LINE_WORDS);
    localparam int unsigned CNT_W   = IDX_W + 1;
    localparam int unsigned OFF_W   = line_off_w(LINE_WORDS, DATA_WIDTH);
    localparam int unsigned WORD_SH = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

    refill_state_t         state_q, state_d;
    port_id_t              port_q, port_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_W-1:0]      iss_q, iss_d;
    logic [CNT_W-1:0]      ret_q, ret_d;

    logic [1:0]            gnt;
    logic                  advance;
    logic                  beat;
    logic [ADDR_WIDTH-1:0] sel_addr;

    cache_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_vld_i),
        .advance (advance),
        .served  (port_q),
        .gnt     (gnt)
    );

    assign sel_addr = gnt[1] ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                             : req_addr_i[ADDR_WIDTH-1:0];

    // State and burst bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            port_q  <= PORT_ICACHE;
            base_q  <= '0;
            iss_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            base_q  <= base_d;
            iss_q   <= iss_d;
            ret_q   <= ret_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        base_d      = base_q;
        iss_d       = iss_q;
        ret_d       = ret_q;
        req_rdy_o   = 2'b00;
        ack_o       = 2'b00;
        fill_vld_o  = 1'b0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        advance     = 1'b0;
        beat        = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by reset so no ready is offered while held in reset.
                req_rdy_o = reset_n ? gnt : 2'b00;
                beat      = |(req_vld_i & req_rdy_o);
                if (beat) begin
                    port_d  = req_rdy_o[1] ? PORT_DCACHE : PORT_ICACHE;
                    base_d  = sel_addr & LINE_MASK;
                    iss_d   = '0;
                    ret_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mem_req_o  = (iss_q < CNT_W'(LINE_WORDS));
                mem_addr_o = base_q + (ADDR_WIDTH'(iss_q) << WORD_SH);
                if (mem_req_o && mem_gnt_i) begin
                    iss_d = iss_q + CNT_W'(1);
                end
                // Only responses to reads actually granted are accepted.
                if (mem_rvld_i && (ret_q < iss_q)) begin
                    fill_vld_o = 1'b1;
                    ret_d      = ret_q + CNT_W'(1);
                    if (ret_q == CNT_W'(LINE_WORDS - 1)) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                ack_o[port_q] = 1'b1;
                advance       = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fill_port_o = port_q;
    assign fill_idx_o  = fill_vld_o ? ret_q[IDX_W-1:0] : '0;
    assign fill_data_o = fill_vld_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_cache_refill_sched.sv
// Self-checking bench for cache_refill_sched: memory responder with
// configurable latency and grant stalls, plus a line-level reference model.
module tb_cache_refill_sched;

    localparam int unsigned LW = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req_vld_i = 2'b00;
    logic [1:0]  req_rdy_o;
    logic [63:0] req_addr_i = '0;
    logic [1:0]  ack_o;
    logic        fill_vld_o;
    logic        fill_port_o;
    logic [1:0]  fill_idx_o;
    logic [31:0] fill_data_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_rvld_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    cache_refill_sched dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_vld_i   (req_vld_i),
        .req_rdy_o   (req_rdy_o),
        .req_addr_i  (req_addr_i),
        .ack_o       (ack_o),
        .fill_vld_o  (fill_vld_o),
        .fill_port_o (fill_port_o),
        .fill_idx_o  (fill_idx_o),
        .fill_data_o (fill_data_o),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_addr_o  (mem_addr_o),
        .mem_rvld_i  (mem_rvld_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;
    bit gnt_rand = 1'b0;
    int spur_cyc = -1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    // Line-level reference model state.
    bit          m_busy = 1'b0;
    bit          m_ack_next = 1'b0;
    bit          m_prio = 1'b0;
    bit          m_port = 1'b0;
    int          m_issued = 0;
    int          m_filled = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[LW];
    int          beats = 0;
    int          acks = 0;
    int          fills = 0;
    int          beat_cyc = 0;
    int          issue_cyc[$];
    logic [31:0] issue_addr[$];
    int          fill_cyc[$];
    int          ack_cyc[$];
    logic [1:0]  ack_val[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    // Round-robin choice: a lone requester wins, a tie goes to the priority port.
    function automatic logic [1:0] rr_pick(input logic [1:0] v, input bit prio);
        if (v == 2'b11) return prio ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beat(input int target, input int budget);
        for (int i = 0; i < budget && beats < target; i++) tick();
        check("beat_wait", beats, target);
    endtask

    task automatic wait_ack(input int target, input int budget);
        for (int i = 0; i < budget && acks < target; i++) tick();
        check("ack_wait", acks, target);
    endtask

    task automatic wait_fills(input int target, input int budget);
        for (int i = 0; i < budget && fills < target; i++) tick();
        check("fill_wait", fills >= target, 1'b1);
    endtask

    // Memory responder: in-order responses 'lat' cycles after each grant.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        mem_rvld_i  = 1'b0;
        mem_rdata_i = $urandom;
        if (!reset_n) begin
            pend.delete();
            mem_gnt_i = 1'b0;
        end else begin
            mem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rvld_i  = 1'b1;
                mem_rdata_i = memfn(pend[0].addr);
                void'(pend.pop_front());
            end else if (cyc == spur_cyc) begin
                mem_rvld_i = 1'b1;
            end
        end
        @(negedge clk);
        if (reset_n && mem_req_o && mem_gnt_i)
            pend.push_back('{addr: mem_addr_o, due: cyc + lat});
    end

    // Monitor: compare every cycle against the line-level model.
    always @(negedge clk) begin
        logic [1:0]  exp_rdy;
        logic        exp_fv;
        logic [31:0] base;
        bit          p;
        if (!reset_n) begin
            check("reset_ctrl", {req_rdy_o, ack_o, fill_vld_o, mem_req_o, fill_port_o, fill_idx_o}, '0);
            check("reset_data", {fill_data_o, mem_addr_o}, '0);
            m_busy = 1'b0;
            m_ack_next = 1'b0;
            m_prio = 1'b0;
            exp_addr.delete();
        end else if (m_ack_next) begin
            check("ack", ack_o, m_port ? 2'b10 : 2'b01);
            check("ack_quiet", {req_rdy_o, mem_req_o, fill_vld_o}, '0);
            ack_cyc.push_back(cyc);
            ack_val.push_back(ack_o);
            acks++;
            m_ack_next = 1'b0;
            m_busy = 1'b0;
            m_prio = ~m_port;
        end else if (m_busy) begin
            check("busy_rdy_ack", {req_rdy_o, ack_o}, '0);
            exp_fv = mem_rvld_i && (m_issued > m_filled);
            check("mem_req", mem_req_o, exp_addr.size() > 0);
            if (exp_addr.size() > 0) begin
                check("mem_addr", mem_addr_o, exp_addr[0]);
                if (mem_gnt_i) begin
                    issue_cyc.push_back(cyc);
                    issue_addr.push_back(mem_addr_o);
                    void'(exp_addr.pop_front());
                    m_issued++;
                end
            end
            check("fill_vld", fill_vld_o, exp_fv);
            if (exp_fv) begin
                check("fill_port", fill_port_o, m_port);
                check("fill_idx", fill_idx_o, m_filled);
                check("fill_data", fill_data_o, exp_data[m_filled]);
                fill_cyc.push_back(cyc);
                fills++;
                m_filled++;
                if (m_filled == LW) m_ack_next = 1'b1;
            end
        end else begin
            exp_rdy = rr_pick(req_vld_i, m_prio);
            check("req_rdy", req_rdy_o, exp_rdy);
            check("idle_quiet", {ack_o, fill_vld_o, mem_req_o}, '0);
            if (exp_rdy != 2'b00) begin
                p    = exp_rdy[1];
                base = (p ? req_addr_i[63:32] : req_addr_i[31:0]) & 32'hFFFF_FFF0;
                m_busy = 1'b1;
                m_port = p;
                m_issued = 0;
                m_filled = 0;
                exp_addr.delete();
                for (int i = 0; i < LW; i++) begin
                    exp_addr.push_back(base + 32'(4 * i));
                    exp_data[i] = memfn(base + 32'(4 * i));
                end
                beats++;
                beat_cyc = cyc;
            end
        end
    end

    initial begin
        int seg_i;
        int seg_f;
        int seg_a;
        int b;
        int tgt;

        // Reset held with both requests high.
        req_vld_i  = 2'b11;
        req_addr_i = {$urandom, $urandom};
        repeat (3) tick();
        check("reset_rdy_held", req_rdy_o, 2'b00);
        reset_n = 1'b1;
        #1;
        check("first_grant", req_rdy_o, 2'b01);

        // Contention: continuous requests alternate 0,1,0,1.
        seg_a = ack_val.size();
        wait_ack(4, 400);
        req_vld_i = 2'b00;
        check("rr_ack_count", ack_val.size() - seg_a, 4);
        for (int i = 0; i < 4; i++)
            check("rr_order", ack_val[seg_a + i], (i % 2) ? 2'b10 : 2'b01);

        // Single line on port 0 with best-case memory.
        tick();
        lat = 1;
        gnt_rand = 1'b0;
        req_addr_i[31:0] = 32'h0000_1234;
        req_vld_i = 2'b01;
        seg_i = issue_cyc.size();
        seg_f = fill_cyc.size();
        seg_a = ack_cyc.size();
        tgt = beats + 1;
        wait_beat(tgt, 20);
        b = beat_cyc;
        req_vld_i = 2'b00;
        req_addr_i[31:0] = $urandom;
        wait_ack(acks + 1, 40);
        repeat (3) tick();
        check("single_issues", issue_cyc.size() - seg_i, 4);
        check("single_fills", fill_cyc.size() - seg_f, 4);
        for (int i = 0; i < 4; i++) begin
            check("single_addr", issue_addr[seg_i + i], 32'h0000_1230 + 32'(4 * i));
            check("single_issue_cyc", issue_cyc[seg_i + i], b + 1 + i);
            check("single_fill_cyc", fill_cyc[seg_f + i], b + 2 + i);
        end
        check("single_acks", ack_cyc.size() - seg_a, 1);
        check("single_ack_cyc", ack_cyc[seg_a], b + 6);
        check("single_ack_val", ack_val[seg_a], 2'b01);

        // Grant stalls with latency 3.
        gnt_rand = 1'b1;
        lat = 3;
        for (int k = 0; k < 3; k++) begin
            req_addr_i = {$urandom, $urandom};
            req_vld_i = (k % 2 == 0) ? 2'b10 : 2'b01;
            seg_f = fills;
            seg_a = acks;
            wait_beat(beats + 1, 20);
            req_vld_i = 2'b00;
            wait_ack(seg_a + 1, 300);
            repeat (2) tick();
            check("stall_fills", fills - seg_f, 4);
            check("stall_acks", acks - seg_a, 1);
        end

        // Spurious responses in IDLE and in BUSY before any grant returns.
        gnt_rand = 1'b0;
        lat = 1;
        seg_f = fills;
        spur_cyc = cyc + 2;
        repeat (5) tick();
        check("spur_idle_fills", fills - seg_f, 0);
        req_addr_i[31:0] = $urandom;
        req_vld_i = 2'b01;
        spur_cyc = cyc + 1;
        seg_a = acks;
        wait_beat(beats + 1, 20);
        req_vld_i = 2'b00;
        wait_ack(seg_a + 1, 40);
        check("spur_busy_fills", fills - seg_f, 4);

        // Reset in the middle of a burst.
        lat = 2;
        req_addr_i[63:32] = $urandom;
        req_vld_i = 2'b10;
        seg_f = fills;
        wait_beat(beats + 1, 20);
        req_vld_i = 2'b00;
        wait_fills(seg_f + 2, 40);
        reset_n = 1'b0;
        #1;
        check("midrst_ctrl", {req_rdy_o, ack_o, fill_vld_o, mem_req_o, fill_port_o, fill_idx_o}, '0);
        check("midrst_data", {fill_data_o, mem_addr_o}, '0);
        repeat (2) tick();
        reset_n = 1'b1;
        lat = 1;
        req_addr_i = {$urandom, 32'hFFFF_FFF8};
        req_vld_i = 2'b11;
        seg_i = issue_addr.size();
        seg_a = ack_val.size();
        wait_beat(beats + 1, 20);
        req_vld_i = 2'b00;
        wait_ack(acks + 1, 40);
        check("wrap_issues", issue_addr.size() - seg_i, 4);
        for (int i = 0; i < 4; i++)
            check("wrap_addr", issue_addr[seg_i + i], 32'hFFFF_FFF0 + 32'(4 * i));
        check("wrap_ack_val", ack_val[seg_a], 2'b01);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
